sram_bus_arbiter: RTL and testbench

//  Multi-cycle controller and 2-way round-robin arbiter for the external 16-bit SRAM.

---
 rtl/sram_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/sram_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared encodings for the SRAM controller: FSM states, strobe word layout, default widths.
// Strobe bits are active-low and ordered {we,ce,oe,lb,ub}; byte enables are active-high {ub,lb}.
package sram_pkg;

  localparam int AW_DEF = 18;
  localparam int DW_DEF = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_STROBE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic [4:0] CTRL_IDLE = 5'b11111;
  localparam int CTRL_WE = 4;
  localparam int CTRL_CE = 3;
  localparam int CTRL_OE = 2;
  localparam int CTRL_LB = 1;
  localparam int CTRL_UB = 0;

  function automatic logic [4:0] ctrl_word(input logic we_n, input logic oe_n, input logic [1:0] be);
    logic [4:0] c;
    c          = CTRL_IDLE;
    c[CTRL_WE] = we_n;
    c[CTRL_CE] = 1'b0;
    c[CTRL_OE] = oe_n;
    c[CTRL_LB] = ~be[0];
    c[CTRL_UB] = ~be[1];
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the one not served last.
// Purely combinational; the last-grant history is owned by the caller.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrated multi-cycle SRAM controller: IDLE -> SETUP -> STROBE(WAIT_STATES+1) -> RECOVER.
// Access period 4+WAIT_STATES cycles; requesters hold req until their one-cycle ack, no preemption.
module sram_bus_arbiter
  import sram_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [1:0]    i_req,
  input  logic [1:0]    i_we_req,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  input  logic [1:0]    i_be0,
  input  logic [1:0]    i_be1,
  output logic [1:0]    o_ack,
  output logic [DW-1:0] o_rdata,
  output logic          o_busy,
  output logic [AW-1:0] o_sram_addr,
  output logic [4:0]    o_control_mem,
  output logic [DW-1:0] o_sram_wdata,
  output logic          o_sram_drive,
  input  logic [DW-1:0] i_sram_rdata
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  logic [1:0]    r_state, w_state_nxt;
  logic [3:0]    r_wait_cnt;
  logic          r_last_grant, r_grant, r_we;
  logic [1:0]    r_be;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [4:0]    r_ctrl;
  logic          r_drive;
  logic [1:0]    r_ack;

  logic          w_grant, w_valid, w_strobe_done;
  logic          w_sel_we, w_cur_we;
  logic [1:0]    w_sel_be, w_cur_be;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [4:0]    w_ctrl_nxt;
  logic          w_drive_nxt;
  logic [1:0]    w_ack_nxt;

  rr_arbiter2 u_arb (
    .i_req        (i_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  assign w_sel_we      = i_we_req[w_grant];
  assign w_sel_be      = w_grant ? i_be1    : i_be0;
  assign w_sel_addr    = w_grant ? i_addr1  : i_addr0;
  assign w_sel_wdata   = w_grant ? i_wdata1 : i_wdata0;
  assign w_strobe_done = (r_state == ST_STROBE) && (r_wait_cnt == 4'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_valid) w_state_nxt = ST_SETUP;
      ST_SETUP:   w_state_nxt = ST_STROBE;
      ST_STROBE:  if (w_strobe_done) w_state_nxt = ST_RECOVER;
      ST_RECOVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered, so they are decoded from the next state; on the IDLE->SETUP
  // edge the bus registers are still loading, hence the bypass to the winner's we/be.
  always_comb begin
    w_cur_we    = (r_state == ST_IDLE) ? w_sel_we : r_we;
    w_cur_be    = (r_state == ST_IDLE) ? w_sel_be : r_be;
    w_ctrl_nxt  = CTRL_IDLE;
    w_drive_nxt = 1'b0;
    w_ack_nxt   = 2'b00;
    case (w_state_nxt)
      ST_SETUP: begin
        w_ctrl_nxt  = ctrl_word(1'b1, w_cur_we, w_cur_be);
        w_drive_nxt = w_cur_we;
      end
      ST_STROBE: begin
        w_ctrl_nxt  = ctrl_word(~w_cur_we, w_cur_we, w_cur_be);
        w_drive_nxt = w_cur_we;
      end
      ST_RECOVER: w_ack_nxt = r_grant ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait_cnt   <= 4'd0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_ctrl       <= CTRL_IDLE;
      r_drive      <= 1'b0;
      r_ack        <= 2'b00;
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_drive <= w_drive_nxt;
      r_ack   <= w_ack_nxt;
      if (r_state == ST_IDLE && w_valid) begin
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
        r_we         <= w_sel_we;
        r_be         <= w_sel_be;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
      end
      if (r_state == ST_SETUP)
        r_wait_cnt <= WS_LOAD;
      else if (r_state == ST_STROBE && r_wait_cnt != 4'd0)
        r_wait_cnt <= r_wait_cnt - 4'd1;
      if (w_strobe_done && !r_we)
        r_rdata <= i_sram_rdata;
    end
  end

  assign o_ack         = r_ack;
  assign o_rdata       = r_rdata;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_sram_addr   = r_addr;
  assign o_control_mem = r_ctrl;
  assign o_sram_wdata  = r_wdata;
  assign o_sram_drive  = r_drive;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: WAIT_STATES=1 main instance plus WS=0 and WS=3 latency instances.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we_req, be0, be1;
  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1, sram_rdata;

  logic [1:0]  ack, ack_w0, ack_w3;
  logic [15:0] rdata, rdata_w0, rdata_w3;
  logic        busy, busy_w0, busy_w3;
  logic [17:0] saddr, saddr_w0, saddr_w3;
  logic [4:0]  ctrl, ctrl_w0, ctrl_w3;
  logic [15:0] swdata, swdata_w0, swdata_w3;
  logic        drive, drive_w0, drive_w3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.AW(18), .DW(16), .WAIT_STATES(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we_req(we_req),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_be0(be0), .i_be1(be1), .o_ack(ack), .o_rdata(rdata), .o_busy(busy),
    .o_sram_addr(saddr), .o_control_mem(ctrl), .o_sram_wdata(swdata),
    .o_sram_drive(drive), .i_sram_rdata(sram_rdata));

  sram_bus_arbiter #(.AW(18), .DW(16), .WAIT_STATES(0)) dut_ws0 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we_req(we_req),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_be0(be0), .i_be1(be1), .o_ack(ack_w0), .o_rdata(rdata_w0), .o_busy(busy_w0),
    .o_sram_addr(saddr_w0), .o_control_mem(ctrl_w0), .o_sram_wdata(swdata_w0),
    .o_sram_drive(drive_w0), .i_sram_rdata(sram_rdata));

  sram_bus_arbiter #(.AW(18), .DW(16), .WAIT_STATES(3)) dut_ws3 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we_req(we_req),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_be0(be0), .i_be1(be1), .o_ack(ack_w3), .o_rdata(rdata_w3), .o_busy(busy_w3),
    .o_sram_addr(saddr_w3), .o_control_mem(ctrl_w3), .o_sram_wdata(swdata_w3),
    .o_sram_drive(drive_w3), .i_sram_rdata(sram_rdata));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 2'b00; we_req = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; be0 = 2'b11; be1 = 2'b11; sram_rdata = '0;
    #3;
    checks++; if (ctrl !== 5'b11111) begin failures++; $display("FAIL reset_ctrl got=%b exp=11111", ctrl); end
    checks++; if (drive !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_drive_busy got=%b%b exp=00", drive, busy); end
    checks++; if (ack !== 2'b00 || rdata !== 16'h0) begin failures++; $display("FAIL reset_ack_rdata got=%b/%h exp=00/0000", ack, rdata); end
    checks++; if (saddr !== 18'h0 || swdata !== 16'h0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", saddr, swdata); end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_cpu;
    req = 2'b01; we_req = 2'b00; addr0 = 18'h00123; be0 = 2'b11; sram_rdata = 16'hBEEF;
    tick();
    checks++; if (ctrl !== 5'b10000) begin failures++; $display("FAIL rd_setup_ctrl got=%b exp=10000", ctrl); end
    checks++; if (saddr !== 18'h00123 || busy !== 1'b1) begin failures++; $display("FAIL rd_setup_addr got=%h/%b exp=00123/1", saddr, busy); end
    tick();
    checks++; if (ctrl !== 5'b10000 || ack !== 2'b00) begin failures++; $display("FAIL rd_strobe1 got=%b/%b exp=10000/00", ctrl, ack); end
    tick();
    checks++; if (ctrl !== 5'b10000 || ack !== 2'b00) begin failures++; $display("FAIL rd_strobe2 got=%b/%b exp=10000/00", ctrl, ack); end
    tick();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL rd_ack got=%b exp=01", ack); end
    checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=beef", rdata); end
    checks++; if (ctrl !== 5'b11111 || drive !== 1'b0) begin failures++; $display("FAIL rd_recover got=%b/%b exp=11111/0", ctrl, drive); end
    req = 2'b00;
    tick();
    checks++; if (ack !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rd_idle got=%b/%b exp=00/0", ack, busy); end
  endtask

  task automatic test_write_req1;
    req = 2'b10; we_req = 2'b10; addr1 = 18'h3FFFF; wdata1 = 16'hA55A; be1 = 2'b01; sram_rdata = 16'h0000;
    tick();
    checks++; if (ctrl !== 5'b10101 || drive !== 1'b1) begin failures++; $display("FAIL wr_setup got=%b/%b exp=10101/1", ctrl, drive); end
    checks++; if (saddr !== 18'h3FFFF || swdata !== 16'hA55A) begin failures++; $display("FAIL wr_bus got=%h/%h exp=3ffff/a55a", saddr, swdata); end
    tick();
    checks++; if (ctrl !== 5'b00101 || drive !== 1'b1) begin failures++; $display("FAIL wr_strobe1 got=%b/%b exp=00101/1", ctrl, drive); end
    tick();
    checks++; if (ctrl !== 5'b00101 || drive !== 1'b1) begin failures++; $display("FAIL wr_strobe2 got=%b/%b exp=00101/1", ctrl, drive); end
    tick();
    checks++; if (ctrl !== 5'b11111 || drive !== 1'b0) begin failures++; $display("FAIL wr_recover got=%b/%b exp=11111/0", ctrl, drive); end
    checks++; if (ack !== 2'b10) begin failures++; $display("FAIL wr_ack got=%b exp=10", ack); end
    checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL wr_rdata_held got=%h exp=beef", rdata); end
    req = 2'b00; we_req = 2'b00;
    tick();
  endtask

  task automatic test_contention;
    int n;
    logic [1:0] exp_ack;
    req = 2'b11; we_req = 2'b00; addr0 = 18'h00010; addr1 = 18'h00020; be0 = 2'b11; be1 = 2'b11;
    for (int a = 0; a < 4; a++) begin
      exp_ack = (a % 2 == 1) ? 2'b10 : 2'b01;
      n = 0;
      while (n < 20) begin
        tick();
        n++;
        if (ack !== 2'b00) break;
      end
      checks++; if (ack !== exp_ack) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", a, ack, exp_ack); end
      checks++; if (n != ((a == 0) ? 4 : 5)) begin failures++; $display("FAIL rr_period%0d got=%0d exp=%0d", a, n, (a == 0) ? 4 : 5); end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_strobe;
    req = 2'b01; we_req = 2'b01; addr0 = 18'h00200; wdata0 = 16'h1234; be0 = 2'b11;
    tick();
    tick();
    checks++; if (ctrl !== 5'b00100 || drive !== 1'b1) begin failures++; $display("FAIL rst_pre_strobe got=%b/%b exp=00100/1", ctrl, drive); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ctrl !== 5'b11111 || drive !== 1'b0) begin failures++; $display("FAIL rst_abort got=%b/%b exp=11111/0", ctrl, drive); end
    checks++; if (ack !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rst_abort_ack got=%b/%b exp=00/0", ack, busy); end
    req = 2'b00; we_req = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    req = 2'b11; addr0 = 18'h00300; addr1 = 18'h00301;
    tick();
    checks++; if (saddr !== 18'h00300) begin failures++; $display("FAIL rst_tie_addr got=%h exp=00300", saddr); end
    tick();
    tick();
    tick();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL rst_tie_grant got=%b exp=01", ack); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_wait_states;
    int n;
    do_reset();
    req = 2'b01; we_req = 2'b00; addr0 = 18'h00ABC; wdata0 = 16'h0F0F; be0 = 2'b11; sram_rdata = 16'h5A5A;
    tick();
    addr0 = 18'h15555;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (ack_w0 !== 2'b00) break;
    end
    checks++; if (n != 2 || ack_w0 !== 2'b01) begin failures++; $display("FAIL ws0_latency got=%0d/%b exp=2/01", n, ack_w0); end
    checks++; if (saddr_w0 !== 18'h00ABC || swdata_w0 !== 16'h0F0F) begin failures++; $display("FAIL ws0_latched got=%h/%h exp=00abc/0f0f", saddr_w0, swdata_w0); end
    checks++; if (rdata_w0 !== 16'h5A5A || ctrl_w0 !== 5'b11111 || drive_w0 !== 1'b0) begin failures++; $display("FAIL ws0_done got=%h/%b/%b exp=5a5a/11111/0", rdata_w0, ctrl_w0, drive_w0); end
    req = 2'b00;
    do_reset();
    req = 2'b01; addr0 = 18'h00DEF;
    tick();
    addr0 = 18'h2AAAA;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (n == 3 && (saddr_w3 !== 18'h00DEF || busy_w3 !== 1'b1)) begin
        failures++; $display("FAIL ws3_mid_addr got=%h/%b exp=00def/1", saddr_w3, busy_w3);
      end
      if (ack_w3 !== 2'b00) break;
    end
    checks++;
    checks++; if (n != 5 || ack_w3 !== 2'b01) begin failures++; $display("FAIL ws3_latency got=%0d/%b exp=5/01", n, ack_w3); end
    checks++; if (saddr_w3 !== 18'h00DEF || rdata_w3 !== 16'h5A5A) begin failures++; $display("FAIL ws3_latched got=%h/%h exp=00def/5a5a", saddr_w3, rdata_w3); end
    checks++; if (ctrl_w3 !== 5'b11111 || drive_w3 !== 1'b0 || swdata_w3 !== 16'h0F0F) begin failures++; $display("FAIL ws3_done got=%b/%b/%h exp=11111/0/0f0f", ctrl_w3, drive_w3, swdata_w3); end
    req = 2'b00;
    do_reset();
  endtask

  task automatic test_be_zero;
    req = 2'b01; we_req = 2'b00; addr0 = 18'h00042; be0 = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (ctrl !== 5'b10011) begin failures++; $display("FAIL be0_ctrl%0d got=%b exp=10011", c, ctrl); end
    end
    tick();
    checks++; if (ack !== 2'b01 || ctrl !== 5'b11111) begin failures++; $display("FAIL be0_ack got=%b/%b exp=01/11111", ack, ctrl); end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_cpu();
    test_write_req1();
    test_contention();
    test_reset_mid_strobe();
    test_wait_states();
    test_be_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
